rpn_exec_ctrl: RTL and testbench

Postfix (RPN) evaluator that sits directly upstream of the stack controller. It accepts a stream of operand/operator tokens over a valid/ready handshake and drives the stack controller's single-cycle push/pop strobes. It reads operands back through the stack's synchronous-RAM data output, computes the arithmetic result and pushes it back. The latest result and a sticky error flag go to the board display logic.

---
 rtl/rpn_exec_ctrl.sv | 133 +++++++++++++
 tb/tb_rpn_exec_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_exec_ctrl.sv
// rpn_exec_ctrl: postfix (RPN) evaluator sitting in front of a stack controller.
// Accepts operand/operator tokens over valid/ready, issues single-cycle
// push/pop strobes, reads operands back through the stack's registered RAM
// output, and pushes the computed result.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   tok_valid/tok_ready  token handshake (ready only when idle)
//   tok_is_op, tok_data  token kind and operand value / operator code [1:0]
//   stack_push/pop/din   strobes and write data to the stack
//   stack_dout           registered RAM read data at the current pointer
//   stack_full/empty     stack occupancy flags
//   stack_pointer        current entry count
//   result/result_valid  last computed result and its one-cycle update pulse
//   busy, err            sequence in progress / sticky error
//
// state   | meaning
// IDLE    | waiting for a token
// PUSH    | pushing an accepted operand
// POP_B   | popping the top entry (b)
// WAIT_B  | RAM registers b at the decremented pointer
// LATCH_B | capture b, pop the next entry (a)
// WAIT_A  | RAM registers a
// LATCH_A | capture a, compute result
// PUSH_R  | push the result, pulse result_valid
// ERR     | sticky error, only rst leaves
module rpn_exec_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic [DATA_WIDTH-1:0] stack_din,
  input  logic [DATA_WIDTH-1:0] stack_dout,
  input  logic                  stack_full,
  input  logic                  stack_empty,
  input  logic [SP_WIDTH-1:0]   stack_pointer,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_B, S_WAIT_B, S_LATCH_B,
    S_WAIT_A, S_LATCH_A, S_PUSH_R, S_ERR
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] alu;
  logic                  take_operand;
  logic                  take_operator;
  logic                  too_few;

  // stack_empty is redundant with the pointer compare but kept as a guard
  assign too_few       = stack_empty || (stack_pointer < SP_WIDTH'(2));
  assign take_operand  = (state == S_IDLE) && tok_valid && !tok_is_op && !stack_full;
  assign take_operator = (state == S_IDLE) && tok_valid && tok_is_op &&
                         (tok_data[1:0] != 2'b11) && !too_few;

  // a (deeper entry) arrives on stack_dout during LATCH_A
  always_comb begin
    alu = '0;
    case (op)
      2'b00:   alu = stack_dout + b_reg;
      2'b01:   alu = stack_dout - b_reg;
      default: alu = stack_dout * b_reg;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op)
            state_nxt = stack_full ? S_ERR : S_PUSH;
          else if (tok_data[1:0] == 2'b11 || too_few)
            state_nxt = S_ERR;
          else
            state_nxt = S_POP_B;
        end
      end
      S_PUSH:    state_nxt = S_IDLE;
      S_POP_B:   state_nxt = S_WAIT_B;
      S_WAIT_B:  state_nxt = S_LATCH_B;
      S_LATCH_B: state_nxt = S_WAIT_A;
      S_WAIT_A:  state_nxt = S_LATCH_A;
      S_LATCH_A: state_nxt = S_PUSH_R;
      S_PUSH_R:  state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_ERR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= 2'b00;
      b_reg     <= '0;
      stack_din <= '0;
      result    <= '0;
    end else begin
      state <= state_nxt;
      if (take_operand)
        stack_din <= tok_data;
      if (take_operator)
        op <= tok_data[1:0];
      if (state == S_LATCH_B)
        b_reg <= stack_dout;
      if (state == S_LATCH_A) begin
        result    <= alu;
        stack_din <= alu;
      end
    end
  end

  assign tok_ready    = (state == S_IDLE);
  assign stack_push   = (state == S_PUSH) || (state == S_PUSH_R);
  assign stack_pop    = (state == S_POP_B) || (state == S_LATCH_B);
  assign result_valid = (state == S_PUSH_R);
  assign busy         = (state != S_IDLE) && (state != S_ERR);
  assign err          = (state == S_ERR);

endmodule

// File: tb/tb_rpn_exec_ctrl.sv
module tb_rpn_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid, tok_ready, tok_is_op;
  logic [7:0] tok_data;
  logic       stack_push, stack_pop;
  logic [7:0] stack_din, stack_dout;
  logic       stack_full, stack_empty;
  logic [4:0] stack_pointer;
  logic [7:0] result;
  logic       result_valid, busy, err;

  rpn_exec_ctrl #(.DATA_WIDTH(8), .SP_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_din(stack_din), .stack_dout(stack_dout),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_pointer(stack_pointer),
    .result(result), .result_valid(result_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // stack model: depth 8, registered read of mem[sp]; not reset by the DUT's rst
  logic       stk_clr;
  logic [7:0] mem [0:15];
  logic [4:0] sp;
  assign stack_pointer = sp;
  assign stack_full    = (sp == 5'd8);
  assign stack_empty   = (sp == 5'd0);

  always @(posedge clk) begin
    if (stk_clr) begin
      sp <= 5'd0;
    end else if (stack_push && sp < 5'd8) begin
      mem[sp[3:0]] <= stack_din;
      sp <= sp + 5'd1;
    end else if (stack_pop && sp > 5'd0) begin
      sp <= sp - 5'd1;
    end
    stack_dout <= mem[sp[3:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  typedef struct { logic [7:0] val; int c; } res_t;
  logic [7:0] exp_push [$];
  res_t       exp_res  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT pushes or presents a result
  always @(negedge clk) begin
    if (stack_push && stack_pop)
      check("push_pop_overlap", 1, 0);
    if (stack_push) begin
      push_cnt++;
      if (exp_push.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_push: got data %0d expected no push", stack_din);
      end else begin
        check("push_data", stack_din, exp_push.pop_front());
      end
    end
    if (stack_pop) pop_cnt++;
    if (result_valid) begin
      if (exp_res.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: got %0d expected no result_valid", result);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        check("result_val", result, r.val);
        check("result_cycle", cyc, r.c);
      end
    end
  end

  task automatic send_token(input logic is_op, input logic [7:0] data,
                            output logic acc, output int e_cyc);
    acc = 1'b0;
    e_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        tok_valid = 1'b1; tok_is_op = is_op; tok_data = data;
        @(posedge clk); #1;
        e_cyc = cyc;
        tok_valid = 1'b0;
        acc = 1'b1;
        break;
      end
    end
  endtask

  task automatic operand(input logic [7:0] v, input logic expect_push);
    logic acc; int e;
    if (expect_push) exp_push.push_back(v);
    send_token(1'b0, v, acc, e);
    check("operand_accepted", acc, 1);
  endtask

  task automatic operator(input logic [1:0] code, input logic [7:0] expv);
    logic acc; int e;
    res_t r;
    exp_push.push_back(expv);
    send_token(1'b1, {6'd0, code}, acc, e);
    check("operator_accepted", acc, 1);
    r.val = expv; r.c = e + 5;
    exp_res.push_back(r);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1'b1; break; end
    end
    check("wait_idle_timeout", done, 1);
  endtask

  task automatic do_reset(input logic clear_stack);
    @(negedge clk);
    rst = 1'b1; stk_clr = clear_stack; tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; stk_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc; int e, p0, q0;
    rst = 1'b1; stk_clr = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; stk_clr = 1'b0;
    @(negedge clk);
    check("rst_push", stack_push, 0);
    check("rst_pop", stack_pop, 0);
    check("rst_din", stack_din, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ready", tok_ready, 1);

    // 5 3 -> two pushes
    p0 = push_cnt;
    operand(8'd5, 1'b1);
    operand(8'd3, 1'b1);
    wait_idle();
    check("sp_after_5_3", sp, 2);
    check("push_cnt_5_3", push_cnt - p0, 2);
    check("err_5_3", err, 0);

    // sub -> 2
    p0 = push_cnt; q0 = pop_cnt;
    operator(2'b01, 8'd2);
    wait_idle();
    repeat (2) @(negedge clk);
    check("sub_pops", pop_cnt - q0, 2);
    check("sub_pushes", push_cnt - p0, 1);
    check("sub_result", result, 2);
    check("sub_sp", sp, 1);

    // 200 100 add -> 44 ; 12 5 mul -> 60 ; 16 16 mul -> 0
    operand(8'd200, 1'b1); operand(8'd100, 1'b1); operator(2'b00, 8'd44);
    wait_idle();
    check("add_result", result, 44);
    operand(8'd12, 1'b1); operand(8'd5, 1'b1); operator(2'b10, 8'd60);
    wait_idle();
    check("mul_result", result, 60);
    operand(8'd16, 1'b1); operand(8'd16, 1'b1); operator(2'b10, 8'd0);
    wait_idle();
    check("mul_wrap_result", result, 0);
    check("sp_after_ops", sp, 4);
    check("err_after_ops", err, 0);

    // rst during WAIT_A: operator accepted at E, WAIT_A is E+3..E+4
    p0 = push_cnt;
    send_token(1'b1, 8'd1, acc, e);
    check("rstwait_accepted", acc, 1);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_ready", tok_ready, 1);
    check("rstwait_push", stack_push, 0);
    check("rstwait_pop", stack_pop, 0);
    check("rstwait_result", result, 0);
    repeat (6) @(negedge clk);
    check("rstwait_no_push", push_cnt - p0, 0);
    check("rstwait_sp", sp, 2);

    // operator with one entry -> err, consumed, sticky
    do_reset(1'b1);
    operand(8'd9, 1'b1);
    wait_idle();
    p0 = push_cnt; q0 = pop_cnt;
    send_token(1'b1, 8'd0, acc, e);
    check("underflow_consumed", acc, 1);
    @(negedge clk);
    check("underflow_err", err, 1);
    check("underflow_busy", busy, 0);
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'd7;
    repeat (8) @(negedge clk);
    check("underflow_ready", tok_ready, 0);
    tok_valid = 1'b0;
    check("underflow_sp", sp, 1);
    check("underflow_no_push", push_cnt - p0, 0);
    check("underflow_no_pop", pop_cnt - q0, 0);
    check("underflow_err_sticky", err, 1);

    // eight operands, ninth overflows
    do_reset(1'b1);
    @(negedge clk);
    check("rst_clears_err", err, 0);
    p0 = push_cnt;
    for (int i = 1; i <= 8; i++) operand(8'(i), 1'b1);
    wait_idle();
    check("full_sp", sp, 8);
    check("full_flag", stack_full, 1);
    operand(8'd9, 1'b0);
    repeat (3) @(negedge clk);
    check("overflow_err", err, 1);
    check("overflow_sp", sp, 8);
    check("overflow_pushes", push_cnt - p0, 8);

    // illegal opcode with a full stack
    do_reset(1'b0);
    q0 = pop_cnt;
    send_token(1'b1, 8'd3, acc, e);
    check("illegal_consumed", acc, 1);
    repeat (3) @(negedge clk);
    check("illegal_err", err, 1);
    check("illegal_no_pop", pop_cnt - q0, 0);
    check("illegal_sp", sp, 8);

    check("push_queue_drained", exp_push.size(), 0);
    check("result_queue_drained", exp_res.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
